// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data-memory / MMIO responder.
package dmem_mmio_pkg;

  // Byte offsets of the registers inside the 32-byte MMIO window.
  localparam logic [4:0] OFF_TXDATA  = 5'h00;
  localparam logic [4:0] OFF_STATUS  = 5'h04;
  localparam logic [4:0] OFF_CYCLE   = 5'h08;
  localparam logic [4:0] OFF_TIMECMP = 5'h0C;
  localparam logic [4:0] OFF_IRQ_EN  = 5'h10;

  // STATUS register bit positions.
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNMAPPED  = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 7;

  // Which region the current address decodes to.
  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

endpackage

// File: rtl/dmem_mmio_if.sv
// Core data port plus TX byte stream and timer interrupt.
interface dmem_mmio_if;
  logic        mem_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        timer_irq;

  // Core / downstream side.
  modport master (
    output mem_we, addr, wdata, tx_ready,
    input  rdata, tx_valid, tx_data, timer_irq
  );

  // Memory responder side.
  modport slave (
    input  mem_we, addr, wdata, tx_ready,
    output rdata, tx_valid, tx_data, timer_irq
  );
endinterface

// File: rtl/dmem_mmio_sync_fifo.sv
// Registered synchronous FIFO with count, full/empty and an overflow pulse.
// The head is presented combinationally from storage; empty shows zero.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot the push needs, so a full FIFO still accepts.
  assign pop_ok     = pop_i & ~empty_o;
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign overflow_o = push_i & full_o & ~pop_ok;

  // Next pointer and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  // NOTE: storage is deliberately not reset; the cleared count makes stale
  // entries unreachable and lets the array map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-port responder: word RAM plus MMIO window with TX FIFO, free-running
// cycle counter and compare-based timer interrupt. Reads are combinational.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input logic        clk,
  input logic        reset,
  dmem_mmio_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  region_t       region;
  logic [4:0]    offset;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_q [DEPTH_WORDS];

  logic ram_we, wr_mmio, wr_unmapped;
  logic wr_txdata, wr_status, wr_cycle, wr_timecmp, wr_irq_en;

  logic          fifo_full, fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_count;

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] timecmp_q, timecmp_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        unm_q, unm_d;
  logic        irq_q, irq_d;
  logic [31:0] status;

  // Word-aligned access only; the byte lane bits carry no meaning here.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.addr[1:0];

  assign offset  = {bus.addr[4:2], 2'b00};
  assign ram_idx = bus.addr[AW+1:2];

  // Address decode: RAM at the bottom, MMIO window at MMIO_BASE.
  always_comb begin
    region = REG_NONE;
    if (bus.addr[31:AW+2] == '0)                 region = REG_RAM;
    else if (bus.addr[31:5] == MMIO_BASE[31:5])  region = REG_MMIO;
  end

  assign ram_we      = bus.mem_we & (region == REG_RAM) & ~reset;
  assign wr_mmio     = bus.mem_we & (region == REG_MMIO);
  assign wr_unmapped = bus.mem_we & (region == REG_NONE);
  assign wr_txdata   = wr_mmio & (offset == OFF_TXDATA);
  assign wr_status   = wr_mmio & (offset == OFF_STATUS);
  assign wr_cycle    = wr_mmio & (offset == OFF_CYCLE);
  assign wr_timecmp  = wr_mmio & (offset == OFF_TIMECMP);
  assign wr_irq_en   = wr_mmio & (offset == OFF_IRQ_EN);

  // Word RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.wdata;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (wr_txdata),
    .pop_i      (bus.tx_ready),
    .wdata_i    (bus.wdata[7:0]),
    .rdata_o    (bus.tx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (fifo_ovf)
  );

  assign bus.tx_valid  = ~fifo_empty;
  assign bus.timer_irq = irq_q;

  // Next state of the MMIO registers; sticky sets beat same-cycle W1C.
  always_comb begin
    cycle_d   = wr_cycle ? bus.wdata : cycle_q + 32'd1;
    timecmp_d = wr_timecmp ? bus.wdata : timecmp_q;
    irq_en_d  = wr_irq_en ? bus.wdata[0] : irq_en_q;
    ovf_d     = ovf_q;
    unm_d     = unm_q;
    if (wr_status && bus.wdata[ST_OVERFLOW]) ovf_d = 1'b0;
    if (wr_status && bus.wdata[ST_UNMAPPED]) unm_d = 1'b0;
    if (fifo_ovf)    ovf_d = 1'b1;
    if (wr_unmapped) unm_d = 1'b1;
    irq_d = irq_en_q & (cycle_q >= timecmp_q);
  end

  // MMIO register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      timecmp_q <= 32'hFFFF_FFFF;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unm_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      timecmp_q <= timecmp_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      unm_q     <= unm_d;
      irq_q     <= irq_d;
    end
  end

  // STATUS image.
  always_comb begin
    status                                 = '0;
    status[ST_FULL]                        = fifo_full;
    status[ST_EMPTY]                       = fifo_empty;
    status[ST_OVERFLOW]                    = ovf_q;
    status[ST_UNMAPPED]                    = unm_q;
    status[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
  end

  // Zero-latency read mux; unmapped and reserved offsets read zero.
  always_comb begin
    bus.rdata = '0;
    case (region)
      REG_RAM:  bus.rdata = ram_q[ram_idx];
      REG_MMIO: begin
        case (offset)
          OFF_STATUS:  bus.rdata = status;
          OFF_CYCLE:   bus.rdata = cycle_q;
          OFF_TIMECMP: bus.rdata = timecmp_q;
          OFF_IRQ_EN:  bus.rdata = {31'd0, irq_en_q};
          default:     bus.rdata = '0;
        endcase
      end
      default:  bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue/array reference model of the register map.
module tb_dmem_mmio;

  localparam int          DEPTH_WORDS = 64;
  localparam int          FIFO_DEPTH  = 8;
  localparam logic [31:0] MMIO_BASE   = 32'h0000_1000;
  localparam logic [31:0] A_TX  = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_ST  = MMIO_BASE + 32'h04;
  localparam logic [31:0] A_CYC = MMIO_BASE + 32'h08;
  localparam logic [31:0] A_CMP = MMIO_BASE + 32'h0C;
  localparam logic [31:0] A_IEN = MMIO_BASE + 32'h10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_mmio_if bus ();

  dmem_mmio #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .MMIO_BASE   (MMIO_BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [31:0] ram_m [int];
  logic [7:0]  fifo_m [$];
  logic [31:0] cyc_m, tcmp_m;
  bit          irqen_m, ovf_m, unm_m, irq_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    fifo_m.delete();
    cyc_m   = 32'd0;
    tcmp_m  = 32'hFFFF_FFFF;
    irqen_m = 1'b0;
    ovf_m   = 1'b0;
    unm_m   = 1'b0;
    irq_m   = 1'b0;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(4 * DEPTH_WORDS);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 5) == (MMIO_BASE >> 5);
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int sz = fifo_m.size();
    int idx = int'(a >> 2);
    known = 1'b1;
    v = 32'd0;
    if (is_ram(a)) begin
      if (ram_m.exists(idx)) v = ram_m[idx];
      else known = 1'b0;
    end else if (is_mmio(a)) begin
      case (a - MMIO_BASE - (a & 32'h3))
        32'h04: v = {17'd0, 7'(sz), 4'd0, unm_m, ovf_m, (sz == 0), (sz == FIFO_DEPTH)};
        32'h08: v = cyc_m;
        32'h0C: v = tcmp_m;
        32'h10: v = {31'd0, irqen_m};
        default: v = 32'd0;
      endcase
    end
  endfunction

  function automatic void model_commit(input logic we, input logic [31:0] a,
                                       input logic [31:0] d, input logic rdy);
    bit pop = (fifo_m.size() != 0) && rdy;
    bit was_full = (fifo_m.size() == FIFO_DEPTH);
    bit ovf_set = 1'b0;
    bit unm_set = 1'b0;
    logic [31:0] cyc_n = cyc_m + 32'd1;
    bit irq_n = irqen_m && (cyc_m >= tcmp_m);
    if (pop) fifo_m.delete(0);
    if (we) begin
      if (is_ram(a)) ram_m[int'(a >> 2)] = d;
      else if (is_mmio(a)) begin
        case (a - MMIO_BASE - (a & 32'h3))
          32'h00: if (!was_full || pop) fifo_m.push_back(d[7:0]); else ovf_set = 1'b1;
          32'h04: begin
            if (d[2]) ovf_m = 1'b0;
            if (d[3]) unm_m = 1'b0;
          end
          32'h08: cyc_n = d;
          32'h0C: tcmp_m = d;
          32'h10: irqen_m = d[0];
          default: ;
        endcase
      end else unm_set = 1'b1;
    end
    if (ovf_set) ovf_m = 1'b1;
    if (unm_set) unm_m = 1'b1;
    cyc_m = cyc_n;
    irq_m = irq_n;
  endfunction

  // One bus cycle: entered and left in the clock-low phase.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    logic [31:0] exp_rd;
    bit known;
    bus.mem_we   = we;
    bus.addr     = a;
    bus.wdata    = d;
    bus.tx_ready = rdy;
    #1;
    model_read(a, exp_rd, known);
    if (known) check($sformatf("rdata@%08h", a), bus.rdata, exp_rd);
    check("tx_valid", 32'(bus.tx_valid), 32'(fifo_m.size() != 0));
    check("tx_data", 32'(bus.tx_data), (fifo_m.size() != 0) ? 32'(fifo_m[0]) : 32'd0);
    check("timer_irq", 32'(bus.timer_irq), 32'(irq_m));
    @(posedge clk);
    model_commit(we, a, d, rdy);
    @(negedge clk);
  endtask

  // Present a read address in the low phase without advancing the clock.
  task automatic peek(input logic [31:0] a, input logic rdy);
    bus.mem_we   = 1'b0;
    bus.addr     = a;
    bus.wdata    = 32'd0;
    bus.tx_ready = rdy;
    #1;
  endtask

  logic [31:0] irq_exp [4];
  logic [31:0] cyc_exp [4];

  initial begin
    bus.mem_we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.tx_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    peek(A_ST, 1'b0);
    check("rst_status", bus.rdata, 32'h0000_0002);
    step(1'b0, A_CMP, 32'd0, 1'b0);
    step(1'b0, A_IEN, 32'd0, 1'b0);

    // RAM write/read, unmapped read leaves the sticky bit alone.
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    peek(32'h10, 1'b0);
    check("ram_rd", bus.rdata, 32'hDEAD_BEEF);
    step(1'b0, 32'h10, 32'd0, 1'b0);
    peek(32'h2000, 1'b0);
    check("unmapped_rd", bus.rdata, 32'd0);
    step(1'b0, 32'h2000, 32'd0, 1'b0);
    peek(A_ST, 1'b0);
    check("unm_bit_clear", 32'(bus.rdata[3]), 32'd0);
    step(1'b0, A_ST, 32'd0, 1'b0);

    // Queue three bytes, then drain them.
    step(1'b1, A_TX, 32'h41, 1'b0);
    step(1'b1, A_TX, 32'h42, 1'b0);
    step(1'b1, A_TX, 32'h43, 1'b0);
    peek(A_ST, 1'b0);
    check("count3", 32'(bus.rdata[14:8]), 32'd3);
    check("head41", 32'(bus.tx_data), 32'h41);
    for (int i = 0; i < 4; i++) step(1'b0, A_ST, 32'd0, 1'b1);
    peek(A_ST, 1'b0);
    check("drained_empty", 32'(bus.rdata[1]), 32'd1);

    // Overflow on the ninth push, then W1C.
    for (int i = 0; i < 9; i++) step(1'b1, A_TX, 32'h60 + 32'(i), 1'b0);
    peek(A_ST, 1'b0);
    check("ovf_set", 32'(bus.rdata[2]), 32'd1);
    check("full_cnt", 32'(bus.rdata[14:8]), 32'd8);
    step(1'b1, A_ST, 32'h4, 1'b0);
    peek(A_ST, 1'b0);
    check("ovf_w1c", 32'(bus.rdata[2]), 32'd0);

    // Push and pop together while full.
    step(1'b1, A_TX, 32'h5A, 1'b1);
    peek(A_ST, 1'b0);
    check("full_pushpop_cnt", 32'(bus.rdata[14:8]), 32'd8);
    check("full_pushpop_ovf", 32'(bus.rdata[2]), 32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, A_ST, 32'd0, 1'b1);

    // Timer interrupt around the counter wrap.
    step(1'b1, A_CMP, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, A_IEN, 32'h1, 1'b0);
    step(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
    irq_exp = '{32'd0, 32'd0, 32'd1, 32'd0};
    cyc_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      peek(A_CYC, 1'b0);
      check($sformatf("irq_seq%0d", i), 32'(bus.timer_irq), irq_exp[i]);
      check($sformatf("cyc_seq%0d", i), bus.rdata, cyc_exp[i]);
      step(1'b0, A_CYC, 32'd0, 1'b0);
    end

    // Asynchronous reset with bytes queued; a write under reset is ignored.
    for (int i = 0; i < 4; i++) step(1'b1, A_TX, 32'h30 + 32'(i), 1'b0);
    step(1'b1, A_CYC, 32'd100, 1'b0);
    step(1'b1, A_CMP, 32'd50, 1'b0);
    step(1'b0, A_CYC, 32'd0, 1'b0);
    bus.mem_we = 1'b1; bus.addr = A_CYC; bus.wdata = 32'h55;
    reset = 1'b1;
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_irq", 32'(bus.timer_irq), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    peek(A_ST, 1'b0);
    check("post_rst_count", 32'(bus.rdata[14:8]), 32'd0);
    peek(A_CYC, 1'b0);
    check("post_rst_cycle", bus.rdata, 32'd0);
    step(1'b0, A_CYC, 32'd0, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [31:0] a;
      logic [31:0] d = $urandom();
      logic we = 1'b0;
      logic rdy = ($urandom_range(0, 2) != 0);
      case (r)
        0, 1, 2: begin a = 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2; we = 1'b1; end
        3, 4:    a = 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
        5:       begin a = A_TX; we = 1'b1; rdy = ($urandom_range(0, 3) == 0); end
        6:       begin a = A_ST; we = $urandom_range(0, 1); end
        7: begin
          a = MMIO_BASE + (32'($urandom_range(2, 7)) << 2);
          we = $urandom_range(0, 1);
          if (a == A_CMP) d = cyc_m + 32'($urandom_range(0, 20));
        end
        8: begin
          a = ($urandom_range(0, 1) != 0) ? (32'h2000 | ($urandom() & 32'hFFF))
                                          : (32'h8000_0000 | $urandom());
          we = $urandom_range(0, 1);
        end
        default: a = MMIO_BASE + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      endcase
      step(we, a, d, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Memory-side responder for the single-cycle core's data port: word RAM plus a small MMIO register window.
- Consumes MemWrite/ALUResult/WriteData and returns ReadData in the same cycle.
- MMIO provides a byte TX FIFO drained over a valid/ready stream, a free-running cycle counter and a compare-based timer interrupt.
- Sits beside the core in the top level, in place of a plain data memory.

Parameters:
- DEPTH_WORDS, 64, RAM size in 32-bit words; power of two, 4..4096.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- MMIO_BASE, 32'h0000_1000, base of the 32-byte MMIO window; must be 32-byte aligned and lie outside the RAM region.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_we  in  1  write strobe (core MemWrite)
- addr  in  32  byte address (core ALUResult); addr[1:0] ignored
- wdata  in  32  write data (core WriteData)
- rdata  out  32  read data (core ReadData); combinational from addr
- tx_valid  out  1  FIFO head available
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  downstream accepts head
- timer_irq  out  1  registered timer interrupt level

Behaviour:
- Decode:
  - RAM when addr < 4*DEPTH_WORDS; index = addr[clog2(DEPTH_WORDS)+1:2].
  - MMIO when addr[31:5] == MMIO_BASE[31:5].
  - Otherwise unmapped.
- Reads: combinational, zero latency. Unmapped reads and reserved MMIO offsets return 0.
- Writes: committed on posedge clk when mem_we=1. Reads in the same cycle return the old value.
- RAM:
  - Not reset; contents X until written.
  - No byte enables; whole-word writes only.
- MMIO offsets:
  - 0x00 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 0x04 STATUS:
    - Read: bit0 full, bit1 empty, bit2 overflow (sticky), bit3 unmapped-write (sticky), bits[14:8] count, others 0.
    - Write: 1 to bit2/bit3 clears that bit (W1C); other bits ignored.
  - 0x08 CYCLE: read returns counter; write loads wdata.
  - 0x0C TIMECMP: read/write.
  - 0x10 IRQ_EN: bit0 read/write, others 0.
- Sticky bits:
  - Unmapped write sets STATUS bit3 next cycle.
  - Push while full with no pop that cycle: byte dropped, STATUS bit2 set.
  - Set and W1C in the same cycle: set wins.
- FIFO:
  - Registered; no bypass. A push into an empty FIFO raises tx_valid the following cycle.
  - Pop when tx_valid & tx_ready; tx_data = head, stable while tx_valid & !tx_ready.
  - Push and pop in the same cycle when full: push accepted, count unchanged.
  - Push and pop in the same cycle otherwise: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- CYCLE:
  - Increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - A write loads wdata with no increment that cycle, so the next cycle reads wdata, then wdata+1.
- timer_irq:
  - Registered: timer_irq <= IRQ_EN[0] & (CYCLE >= TIMECMP), unsigned, evaluated on current register values.
  - Cleared only by raising TIMECMP, clearing IRQ_EN, or CYCLE wrapping.
- Reset values:
  - CYCLE=0, TIMECMP=32'hFFFF_FFFF, IRQ_EN=0, sticky bits 0, FIFO empty.
  - tx_valid=0, tx_data=0, timer_irq=0.
  - rdata follows decode (RAM X).
- Reset mid-operation: FIFO contents discarded and tx_valid drops immediately (asynchronous). A write with reset asserted has no effect.

Decomposition:
- Package dmem_mmio_pkg:
  - MMIO offset constants (OFF_TXDATA, OFF_STATUS, OFF_CYCLE, OFF_TIMECMP, OFF_IRQ_EN).
  - STATUS bit-index constants.
  - Region-select enum {REG_RAM, REG_MMIO, REG_NONE}.
- Sub-module sync_fifo #(WIDTH, DEPTH): push/pop, full/empty/count, overflow pulse. Instantiated with WIDTH=8.

Test Plan:
- Write 32'hDEADBEEF to 0x10, then read 0x10 -> rdata=32'hDEADBEEF; read 0x2000 (unmapped) -> 0, STATUS bit3 stays 0.
- Push 'A','B','C' to 0x1000 with tx_ready=0 -> STATUS count=3, tx_valid=1, tx_data=8'h41; set tx_ready=1 -> bytes 41,42,43 in consecutive cycles, then empty=1.
- Push 9 bytes with tx_ready=0 (FIFO_DEPTH=8) -> 9th dropped, STATUS bit2=1; write 32'h4 to STATUS -> bit2=0.
- With full FIFO, tx_ready=1 and push 8'h5A in the same cycle -> count stays 8, 8'h5A is emerged last.
- Write CYCLE=32'hFFFF_FFFE, TIMECMP=32'hFFFF_FFFF, IRQ_EN=1 -> timer_irq rises one cycle after CYCLE reaches FFFF_FFFF, falls one cycle after wrap to 0.
- Assert reset with 4 bytes queued and CYCLE=100 -> tx_valid=0 immediately; after release count=0, CYCLE reads 0, timer_irq=0.
